fetch_controller: RTL and testbench

Sequencing controller for the instruction-fetch stage. Owns the program counter and decides the next PC each cycle from reset, interrupt, return, branch and sequential sources. Drives the IF/ID stall and flush controls, the LDM immediate-word phase, and the multi-cycle interrupt entry sequence (drain, save PC, vector). Sits between the hazard/branch logic and the fetch datapath with its instruction memory.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_pc_mux.sv | 28 ++
 rtl/fetch_controller.sv | 188 ++++++++++++++++++
 tb/tb_fetch_controller.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch controller: FSM states,
// next-PC select codes, PC type and default vectors.
package fetch_pkg;

  localparam int          PC_W    = 32;
  localparam logic [31:0] RST_VEC = 32'h0000_0020;
  localparam logic [31:0] INT_VEC = 32'h0000_0000;

  typedef logic [PC_W-1:0] pc_t;

  typedef enum logic [2:0] {
    RUN       = 3'd0,
    IMM       = 3'd1,
    INT_DRAIN = 3'd2,
    INT_SAVE  = 3'd3,
    INT_JUMP  = 3'd4,
    RET_WAIT  = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BR,
    SEL_RET,
    SEL_INT
  } pc_sel_e;

endpackage

// File: rtl/fetch_pc_mux.sv
// Combinational next-PC select: hold, pc+1 (wrapping), branch, return, vector.
// Ports: sel_i code, pc_i current, br_i/ret_i/vec_i sources, pc_o result.
module fetch_pc_mux
  import fetch_pkg::*;
#(
  parameter int W = PC_W
) (
  input  pc_sel_e        sel_i,
  input  logic [W-1:0]   pc_i,
  input  logic [W-1:0]   br_i,
  input  logic [W-1:0]   ret_i,
  input  logic [W-1:0]   vec_i,
  output logic [W-1:0]   pc_o
);

  always_comb begin
    pc_o = pc_i;
    unique case (sel_i)
      SEL_HOLD: pc_o = pc_i;
      SEL_SEQ:  pc_o = pc_i + W'(1);
      SEL_BR:   pc_o = br_i;
      SEL_RET:  pc_o = ret_i;
      SEL_INT:  pc_o = vec_i;
      default:  pc_o = pc_i;
    endcase
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the PC, IF/ID stall/flush, LDM immediate phase
// and interrupt entry (drain, save PC, vector). Inputs: enable, branch_*,
// return_*, interrupt, ldm_detect, push_ack. Outputs: pc, next_pc, imm_phase,
// if_id_stall/flush, int_push_req, int_saved_pc, state_out.
// Optional FETCH_STALL_CNT_EN adds stall_count (saturating stall/flush cycles).
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_W,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = PC_WIDTH'(RST_VEC),
  parameter logic [PC_WIDTH-1:0] INT_VECTOR   = PC_WIDTH'(INT_VEC),
  parameter int                  DRAIN_CYCLES = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                branch_req,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                return_req,
  input  logic [PC_WIDTH-1:0] return_pc,
  input  logic                return_valid,
  input  logic                interrupt,
  input  logic                ldm_detect,
  input  logic                push_ack,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] next_pc,
  output logic                imm_phase,
  output logic                if_id_stall,
  output logic                if_id_flush,
  output logic                int_push_req,
  output logic [PC_WIDTH-1:0] int_saved_pc,
  output logic [2:0]          state_out
`ifdef FETCH_STALL_CNT_EN
  ,
  output logic [15:0]         stall_count
`endif
);

  localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] npc_q;
  logic [PC_WIDTH-1:0] saved_q, saved_d;
  logic [PC_WIDTH-1:0] brt_q, brt_d;
  logic                brp_q, brp_d;
  logic                pend_q, pend_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  pc_sel_e             sel;

  logic                int_go;
  logic                br_go;
  logic [PC_WIDTH-1:0] br_tgt;

  // A branch caught during IMM is older than one arriving now.
  assign int_go = pend_q | interrupt;
  assign br_go  = brp_q | branch_req;
  assign br_tgt = brp_q ? brt_q : branch_target;

  fetch_pc_mux #(.W(PC_WIDTH)) u_mux (
    .sel_i (sel),
    .pc_i  (pc_q),
    .br_i  (br_tgt),
    .ret_i (return_pc),
    .vec_i (INT_VECTOR),
    .pc_o  (pc_d)
  );

  always_comb begin
    state_d      = state_q;
    sel          = SEL_HOLD;
    saved_d      = saved_q;
    brp_d        = brp_q;
    brt_d        = brt_q;
    pend_d       = pend_q | interrupt;
    cnt_d        = cnt_q;
    imm_phase    = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    int_push_req = 1'b0;
    unique case (state_q)
      RUN: begin
        brp_d = 1'b0;
        if (int_go) begin
          // Save the branch target so a simultaneous branch is not lost.
          state_d     = INT_DRAIN;
          if_id_flush = 1'b1;
          cnt_d       = '0;
          saved_d     = br_go ? br_tgt : pc_q;
        end else if (return_req) begin
          state_d     = RET_WAIT;
          if_id_flush = 1'b1;
        end else if (br_go) begin
          sel         = SEL_BR;
          if_id_flush = 1'b1;
        end else if (!enable) begin
          if_id_stall = 1'b1;
        end else begin
          sel = SEL_SEQ;
          if (ldm_detect) state_d = IMM;
        end
      end
      IMM: begin
        imm_phase = 1'b1;
        if (branch_req) begin
          brp_d = 1'b1;
          brt_d = branch_target;
        end
        if (!enable) begin
          if_id_stall = 1'b1;
        end else begin
          sel     = SEL_SEQ;
          state_d = RUN;
        end
      end
      INT_DRAIN: begin
        if_id_flush = 1'b1;
        if (cnt_q == CNT_LAST) state_d = INT_SAVE;
        else cnt_d = cnt_q + CW'(1);
      end
      INT_SAVE: begin
        // PC still points at the saved word; keep it out of decode.
        if_id_flush  = 1'b1;
        int_push_req = 1'b1;
        if (push_ack) begin
          state_d = INT_JUMP;
          pend_d  = interrupt;
        end
      end
      INT_JUMP: begin
        if_id_flush = 1'b1;
        sel         = SEL_INT;
        state_d     = RUN;
      end
      RET_WAIT: begin
        if_id_flush = 1'b1;
        if (return_valid) begin
          sel     = SEL_RET;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      pc_q    <= RESET_VECTOR;
      npc_q   <= RESET_VECTOR + PC_WIDTH'(1);
      saved_q <= '0;
      brt_q   <= '0;
      brp_q   <= 1'b0;
      pend_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= pc_d + PC_WIDTH'(1);
      saved_q <= saved_d;
      brt_q   <= brt_d;
      brp_q   <= brp_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign next_pc      = npc_q;
  assign int_saved_pc = saved_q;
  assign state_out    = state_q;

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] scnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scnt_q <= '0;
    end else if ((if_id_stall || if_id_flush) && scnt_q != 16'hFFFF) begin
      scnt_q <= scnt_q + 16'd1;
    end
  end

  assign stall_count = scnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Directed table-driven bench for fetch_controller.
// Each row: inputs for one cycle and the outputs expected in that cycle.
module tb_fetch_controller;

  localparam logic [2:0] S_RUN = 3'd0;
  localparam logic [2:0] S_IMM = 3'd1;
  localparam logic [2:0] S_DRN = 3'd2;
  localparam logic [2:0] S_SAV = 3'd3;
  localparam logic [2:0] S_JMP = 3'd4;
  localparam logic [2:0] S_RET = 3'd5;

  // control bits {en, br, rr, rv, irq, ldm, ack}
  localparam logic [6:0] E = 7'b1000000;
  localparam logic [6:0] B = 7'b0100000;
  localparam logic [6:0] R = 7'b0010000;
  localparam logic [6:0] V = 7'b0001000;
  localparam logic [6:0] I = 7'b0000100;
  localparam logic [6:0] L = 7'b0000010;
  localparam logic [6:0] A = 7'b0000001;
  localparam logic [6:0] N = 7'b0000000;

  // expected flags {imm, stall, flush, push}
  localparam logic [3:0] IM = 4'b1000;
  localparam logic [3:0] ST = 4'b0100;
  localparam logic [3:0] FL = 4'b0010;
  localparam logic [3:0] PU = 4'b0001;
  localparam logic [3:0] NO = 4'b0000;

  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] bt;
    logic [31:0] rp;
    logic [31:0] pc;
    logic [2:0]  st;
    logic [3:0]  fl;
    logic [31:0] sv;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable, branch_req, return_req, return_valid;
  logic        interrupt, ldm_detect, push_ack;
  logic [31:0] branch_target, return_pc;
  logic [31:0] pc, next_pc, int_saved_pc;
  logic        imm_phase, if_id_stall, if_id_flush, int_push_req;
  logic [2:0]  state_out;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_controller dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .branch_req    (branch_req),
    .branch_target (branch_target),
    .return_req    (return_req),
    .return_pc     (return_pc),
    .return_valid  (return_valid),
    .interrupt     (interrupt),
    .ldm_detect    (ldm_detect),
    .push_ack      (push_ack),
    .pc            (pc),
    .next_pc       (next_pc),
    .imm_phase     (imm_phase),
    .if_id_stall   (if_id_stall),
    .if_id_flush   (if_id_flush),
    .int_push_req  (int_push_req),
    .int_saved_pc  (int_saved_pc),
    .state_out     (state_out)
`ifdef FETCH_STALL_CNT_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [6:0] c, input logic [31:0] bt,
                              input logic [31:0] rp, input logic [31:0] p,
                              input logic [2:0] s, input logic [3:0] f,
                              input logic [31:0] sv);
    vec_t v;
    v.ctl = c; v.bt = bt; v.rp = rp; v.pc = p;
    v.st = s; v.fl = f; v.sv = sv;
    return v;
  endfunction

  task automatic drive(input logic [6:0] c, input logic [31:0] bt,
                       input logic [31:0] rp);
    {enable, branch_req, return_req, return_valid,
     interrupt, ldm_detect, push_ack} = c;
    branch_target = bt;
    return_pc     = rp;
  endtask

  task automatic chk_outs(input int row, input logic [31:0] p,
                          input logic [2:0] s, input logic [3:0] f,
                          input logic [31:0] sv);
    logic [31:0] np;
    np = p + 32'd1;
    chk("pc",      row, pc, p);
    chk("next_pc", row, next_pc, np);
    chk("state",   row, 32'(state_out), 32'(s));
    chk("imm",     row, 32'(imm_phase), 32'(f[3]));
    chk("stall",   row, 32'(if_id_stall), 32'(f[2]));
    chk("flush",   row, 32'(if_id_flush), 32'(f[1]));
    chk("push",    row, 32'(int_push_req), 32'(f[0]));
    chk("saved",   row, int_saved_pc, sv);
  endtask

  vec_t tbl[$];

  initial begin
    tbl.push_back(mk(E,   0, 0, 32'h20, S_RUN, NO, 0));
    tbl.push_back(mk(E,   0, 0, 32'h21, S_RUN, NO, 0));
    tbl.push_back(mk(E,   0, 0, 32'h22, S_RUN, NO, 0));
    tbl.push_back(mk(E,   0, 0, 32'h23, S_RUN, NO, 0));
    tbl.push_back(mk(E,   0, 0, 32'h24, S_RUN, NO, 0));
    tbl.push_back(mk(N,   0, 0, 32'h25, S_RUN, ST, 0));
    tbl.push_back(mk(E|B, 32'h30, 0, 32'h25, S_RUN, FL, 0));
    tbl.push_back(mk(E|L, 0, 0, 32'h30, S_RUN, NO, 0));
    tbl.push_back(mk(E,   0, 0, 32'h31, S_IMM, IM, 0));
    tbl.push_back(mk(E,   0, 0, 32'h32, S_RUN, NO, 0));
    tbl.push_back(mk(E|B, 32'h40, 0, 32'h33, S_RUN, FL, 0));
    tbl.push_back(mk(B,   32'h80, 0, 32'h40, S_RUN, FL, 0));
    tbl.push_back(mk(E,   0, 0, 32'h80, S_RUN, NO, 0));
    tbl.push_back(mk(E|B, 32'h50, 0, 32'h81, S_RUN, FL, 0));
    tbl.push_back(mk(E|I, 0, 0, 32'h50, S_RUN, FL, 0));
    tbl.push_back(mk(E,   0, 0, 32'h50, S_DRN, FL, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h50, S_DRN, FL, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h50, S_DRN, FL, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h50, S_SAV, FL|PU, 32'h50));
    tbl.push_back(mk(E|A, 0, 0, 32'h50, S_SAV, FL|PU, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h50, S_JMP, FL, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h00, S_RUN, NO, 32'h50));
    tbl.push_back(mk(E|R, 0, 0, 32'h01, S_RUN, FL, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h01, S_RET, FL, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h01, S_RET, FL, 32'h50));
    tbl.push_back(mk(E|V, 0, 32'h51, 32'h01, S_RET, FL, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h51, S_RUN, NO, 32'h50));
    tbl.push_back(mk(E|R|B, 32'h90, 0, 32'h52, S_RUN, FL, 32'h50));
    tbl.push_back(mk(E|V|I, 0, 32'h60, 32'h52, S_RET, FL, 32'h50));
    tbl.push_back(mk(E|B, 32'h70, 0, 32'h60, S_RUN, FL, 32'h50));
    tbl.push_back(mk(E,   0, 0, 32'h60, S_DRN, FL, 32'h70));
    tbl.push_back(mk(E,   0, 0, 32'h60, S_DRN, FL, 32'h70));
    tbl.push_back(mk(E,   0, 0, 32'h60, S_DRN, FL, 32'h70));
    tbl.push_back(mk(E|A, 0, 0, 32'h60, S_SAV, FL|PU, 32'h70));
    tbl.push_back(mk(E,   0, 0, 32'h60, S_JMP, FL, 32'h70));
    tbl.push_back(mk(E,   0, 0, 32'h00, S_RUN, NO, 32'h70));
    tbl.push_back(mk(E|B, 32'hFFFF_FFFF, 0, 32'h01, S_RUN, FL, 32'h70));
    tbl.push_back(mk(E,   0, 0, 32'hFFFF_FFFF, S_RUN, NO, 32'h70));
    tbl.push_back(mk(E|L, 0, 0, 32'h00, S_RUN, NO, 32'h70));
    tbl.push_back(mk(E|I|B, 32'hA0, 0, 32'h01, S_IMM, IM, 32'h70));
    tbl.push_back(mk(E,   0, 0, 32'h02, S_RUN, FL, 32'h70));
    tbl.push_back(mk(E,   0, 0, 32'h02, S_DRN, FL, 32'hA0));
    tbl.push_back(mk(E,   0, 0, 32'h02, S_DRN, FL, 32'hA0));
    tbl.push_back(mk(E,   0, 0, 32'h02, S_DRN, FL, 32'hA0));
    tbl.push_back(mk(E,   0, 0, 32'h02, S_SAV, FL|PU, 32'hA0));

    reset = 1'b0;
    drive(E, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk_outs(-1, 32'h20, S_RUN, NO, 0);
    reset = 1'b1;

    for (int r = 0; r < tbl.size(); r++) begin
      drive(tbl[r].ctl, tbl[r].bt, tbl[r].rp);
      @(negedge clk);
      chk_outs(r, tbl[r].pc, tbl[r].st, tbl[r].fl, tbl[r].sv);
      @(posedge clk);
      #1;
    end

    // Reset dropped mid-cycle while waiting for push_ack.
    drive(E, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk_outs(100, 32'h20, S_RUN, NO, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk_outs(101, 32'h20, S_RUN, NO, 0);
    @(posedge clk);
    #1;
    chk_outs(102, 32'h21, S_RUN, NO, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
